// File: rtl/cnt_sched_pkg.sv
// Shared types and the round-robin pick helper for the interval scheduler.
package cnt_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    // Widest requester vector rr_pick can arbitrate; NREQ must not exceed it.
    localparam int MAX_NREQ = 32;
    localparam int IDXW     = 5;

    // One-hot grant for the first set request found scanning upward from ptr, wrapping at nreq.
    function automatic logic [MAX_NREQ-1:0] rr_pick(
        input logic [MAX_NREQ-1:0] req,
        input int unsigned         nreq,
        input int unsigned         ptr
    );
        logic [MAX_NREQ-1:0] grant;
        logic                found;
        logic [31:0]         idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_NREQ; k++) begin
            idx = (ptr + k) % nreq;
            if (!found && (k < nreq) && req[idx[IDXW-1:0]]) begin
                grant[idx[IDXW-1:0]] = 1'b1;
                found                = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/cnt_load_up.sv
// Loadable WIDTH-bit up counter; load wins over count and counting stops at all-ones.
module cnt_load_up #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_count,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_din;
        end else if (i_count && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/cnt_interval_sched.sv
// Round-robin scheduler sharing one up-counter between NREQ interval requesters.
// Define PAUSE_EN to add the i_hold port, which freezes counting while in COUNT.
module cnt_interval_sched
    import cnt_sched_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NREQ  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ*WIDTH-1:0] i_start_val,
`ifdef PAUSE_EN
    input  logic                  i_hold,
`endif
    output logic [NREQ-1:0]       o_gnt,
    output logic [NREQ-1:0]       o_done,
    output logic                  o_busy,
    output logic [WIDTH-1:0]      o_cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    sched_state_t        r_state;
    sched_state_t        w_nextState;
    logic [NREQ-1:0]     r_gnt;
    logic [NREQ-1:0]     r_done;
    logic [PW-1:0]       r_rrPtr;
    logic [PW-1:0]       r_owner;
    logic [WIDTH-1:0]    r_start;
    logic [MAX_NREQ-1:0] w_pickFull;
    logic [NREQ-1:0]     w_pick;
    logic [PW-1:0]       w_pickIdx;
    logic [WIDTH-1:0]    w_startSel;
    logic [WIDTH-1:0]    w_cnt;
    logic                w_anyReq;
    logic                w_atMax;
    logic                w_hold;
    logic                w_ctrLoad;
    logic                w_ctrCount;

`ifdef PAUSE_EN
    assign w_hold = i_hold;
`else
    assign w_hold = 1'b0;
`endif

    // Reducing the full pick vector (not i_req) keeps every bit of the helper's result in use.
    assign w_pickFull = rr_pick(MAX_NREQ'(i_req), NREQ, 32'(r_rrPtr));
    assign w_pick     = w_pickFull[NREQ-1:0];
    assign w_anyReq   = |w_pickFull;
    assign w_atMax    = (w_cnt == '1);

    always_comb begin
        w_pickIdx  = '0;
        w_startSel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick[i]) begin
                w_pickIdx  = PW'(i);
                w_startSel = i_start_val[i*WIDTH +: WIDTH];
            end
        end
    end

    // Counting is never enabled at all-ones, so the shared counter cannot wrap.
    always_comb begin
        w_nextState = r_state;
        w_ctrLoad   = 1'b0;
        w_ctrCount  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_anyReq) w_nextState = LOAD;
            end
            LOAD: begin
                w_ctrLoad   = 1'b1;
                w_nextState = COUNT;
            end
            COUNT: begin
                if (!w_hold) begin
                    if (w_atMax) w_nextState = DONE;
                    else         w_ctrCount  = 1'b1;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_rrPtr <= '0;
            r_owner <= '0;
            r_start <= '0;
        end else begin
            r_state <= w_nextState;
            r_done  <= '0;
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_gnt   <= w_pick;
                        r_owner <= w_pickIdx;
                        r_start <= w_startSel;
                    end
                end
                COUNT: begin
                    if (w_nextState == DONE) r_done <= r_gnt;
                end
                DONE: begin
                    r_gnt   <= '0;
                    r_rrPtr <= (r_owner == PW'(NREQ-1)) ? '0 : r_owner + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    cnt_load_up #(
        .WIDTH (WIDTH)
    ) u_ctr (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_ctrLoad),
        .i_count (w_ctrCount),
        .i_din   (r_start),
        .o_cnt   (w_cnt)
    );

    assign o_gnt  = r_gnt;
    assign o_done = r_done;
    assign o_busy = (r_state != IDLE);
    assign o_cnt  = w_cnt;

endmodule

// File: tb/tb_cnt_interval_sched.sv
// Directed bench for cnt_interval_sched with a done-pulse scoreboard.
module tb_cnt_interval_sched;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [7:0] startVal;
    logic       hold;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic [3:0] cnt;

    int nChecks;
    int nPass;
    int nFail;

    logic [1:0] sb[$];
    logic [1:0] expDone;

    cnt_interval_sched #(
        .WIDTH (4),
        .NREQ  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (req),
        .i_start_val (startVal),
`ifdef PAUSE_EN
        .i_hold      (hold),
`endif
        .o_gnt       (gnt),
        .o_done      (done),
        .o_busy      (busy),
        .o_cnt       (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] reqV, input logic [3:0] start0, input logic [3:0] start1);
        req      = reqV;
        startVal = {start1, start0};
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every done pulse must match the next queued owner and occur at all-ones.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            if (done !== 2'b00) begin
                if (sb.size() == 0) begin
                    checkOutput("done_unexpected", 32'(done), 32'd0);
                end else begin
                    expDone = sb.pop_front();
                    checkOutput("done_owner", 32'(done), 32'(expDone));
                    checkOutput("done_cnt", 32'(cnt), 32'hF);
                end
            end
        end
    end

    initial begin
        nChecks = 0;
        nPass   = 0;
        nFail   = 0;
        rst     = 1'b1;
        hold    = 1'b0;
        applyStimulus(2'b00, 4'h0, 4'h0);

        tick(2);
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_cnt", 32'(cnt), 32'd0);
        rst = 1'b0;
        tick(1);

        $display("[TB] single requester, start C");
        applyStimulus(2'b01, 4'hC, 4'h0);
        sb.push_back(2'b01);
        tick(1);
        checkOutput("t1_gnt", 32'(gnt), 32'h1);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        applyStimulus(2'b00, 4'h3, 4'h0);
        tick(1);
        checkOutput("t1_cnt_e2", 32'(cnt), 32'hC);
        tick(1);
        checkOutput("t1_cnt_e3", 32'(cnt), 32'hD);
        tick(2);
        checkOutput("t1_cnt_e5", 32'(cnt), 32'hF);
        checkOutput("t1_nodone_e5", 32'(done), 32'd0);
        tick(1);
        checkOutput("t1_done_e6", 32'(done), 32'h1);
        tick(1);
        checkOutput("t1_busy_e7", 32'(busy), 32'd0);
        checkOutput("t1_gnt_e7", 32'(gnt), 32'd0);

        $display("[TB] simultaneous requests from reset");
        rst = 1'b1;
        #1;
        rst = 1'b0;
        applyStimulus(2'b11, 4'hE, 4'hD);
        sb.push_back(2'b01);
        sb.push_back(2'b10);
        tick(1);
        checkOutput("t2_gnt0", 32'(gnt), 32'h1);
        applyStimulus(2'b10, 4'hE, 4'hD);
        tick(1);
        checkOutput("t2_cnt_E", 32'(cnt), 32'hE);
        tick(2);
        checkOutput("t2_done0", 32'(done), 32'h1);
        tick(1);
        checkOutput("t2_idle_gap", 32'(busy), 32'd0);
        tick(1);
        checkOutput("t2_gnt1", 32'(gnt), 32'h2);
        applyStimulus(2'b00, 4'hE, 4'hD);
        tick(1);
        checkOutput("t2_cnt_D", 32'(cnt), 32'hD);
        tick(2);
        checkOutput("t2_cnt_F", 32'(cnt), 32'hF);
        tick(1);
        checkOutput("t2_done1", 32'(done), 32'h2);
        tick(1);
        checkOutput("t2_busy_end", 32'(busy), 32'd0);

        $display("[TB] fairness with start F");
        applyStimulus(2'b11, 4'hF, 4'hF);
        for (int k = 0; k < 4; k++) sb.push_back((k % 2 == 0) ? 2'b01 : 2'b10);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            checkOutput("t3_gnt", 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick(1);
            checkOutput("t3_cnt_load_F", 32'(cnt), 32'hF);
            tick(1);
            checkOutput("t3_done", 32'(done), (k % 2 == 0) ? 32'h1 : 32'h2);
            checkOutput("t3_nowrap", 32'(cnt), 32'hF);
            tick(1);
            checkOutput("t3_idle_gap", 32'(busy), 32'd0);
            if (k == 3) applyStimulus(2'b00, 4'hF, 4'hF);
        end

        $display("[TB] start 0, full 15 increments");
        applyStimulus(2'b01, 4'h0, 4'h0);
        sb.push_back(2'b01);
        tick(1);
        checkOutput("t4_gnt", 32'(gnt), 32'h1);
        applyStimulus(2'b00, 4'h0, 4'h0);
        tick(1);
        checkOutput("t4_cnt_0", 32'(cnt), 32'h0);
        tick(15);
        checkOutput("t4_cnt_F", 32'(cnt), 32'hF);
        checkOutput("t4_nodone", 32'(done), 32'd0);
        tick(1);
        checkOutput("t4_done", 32'(done), 32'h1);
        tick(1);
        checkOutput("t4_busy_end", 32'(busy), 32'd0);

        $display("[TB] reset mid-count");
        applyStimulus(2'b01, 4'h0, 4'h0);
        tick(1);
        checkOutput("t5_gnt_wrap", 32'(gnt), 32'h1);
        applyStimulus(2'b00, 4'h0, 4'h0);
        tick(8);
        checkOutput("t5_cnt_7", 32'(cnt), 32'h7);
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_cnt", 32'(cnt), 32'd0);
        checkOutput("t5_rst_gnt", 32'(gnt), 32'd0);
        checkOutput("t5_rst_busy", 32'(busy), 32'd0);
        checkOutput("t5_rst_done", 32'(done), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(2);
        checkOutput("t5_post_busy", 32'(busy), 32'd0);
        applyStimulus(2'b11, 4'hF, 4'hF);
        sb.push_back(2'b01);
        tick(1);
        checkOutput("t5_ptr_reset_gnt", 32'(gnt), 32'h1);
        applyStimulus(2'b00, 4'hF, 4'hF);
        tick(3);
        checkOutput("t5_busy_end", 32'(busy), 32'd0);

`ifdef PAUSE_EN
        $display("[TB] hold for three cycles at 9");
        applyStimulus(2'b01, 4'h8, 4'h0);
        sb.push_back(2'b01);
        tick(1);
        checkOutput("t6_gnt", 32'(gnt), 32'h1);
        applyStimulus(2'b00, 4'h8, 4'h0);
        tick(2);
        checkOutput("t6_cnt_9", 32'(cnt), 32'h9);
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            checkOutput("t6_hold_cnt", 32'(cnt), 32'h9);
            checkOutput("t6_hold_busy", 32'(busy), 32'd1);
        end
        hold = 1'b0;
        tick(1);
        checkOutput("t6_resume_A", 32'(cnt), 32'hA);
        tick(5);
        checkOutput("t6_cnt_F", 32'(cnt), 32'hF);
        checkOutput("t6_nodone", 32'(done), 32'd0);
        tick(1);
        checkOutput("t6_done", 32'(done), 32'h1);
        tick(1);
        checkOutput("t6_busy_end", 32'(busy), 32'd0);
`endif

        tick(2);
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
